// File: rtl/sp_writeback.sv
// ---------------------------------------------------------------------------
// sp_writeback
//   Takes one result matrix per handshake and streams its elements into a
//   scratchpad section, one element per cycle, in row-major order. Only the
//   valid rows_m1 x cols_m1 window is written unless SP_WB_CLEAR_EN is
//   defined. With that macro, the block sweeps every element address and
//   writes zero outside the window.
//
//   Optional feature macro: SP_WB_CLEAR_EN
//
//   Ports
//     clk_i        : clock, all state on the rising edge
//     reset_ni     : asynchronous active-low reset
//     res_valid_i  : result matrix offered
//     res_ready_o  : block is idle and can accept a result
//     res_mat_i    : flat matrix, element k at [(k+1)*BW-1 -: BW]
//     sp_sel_i     : destination scratchpad section
//     rows_m1_i    : valid rows - 1
//     cols_m1_i    : valid columns - 1
//     sp_ena_o     : scratchpad write enable
//     sp_addr_o    : scratchpad element address (row*MAX_DIM+col)
//     sp_data_o    : scratchpad write data
//     sp_sel_o     : scratchpad section of the current write
//     busy_o       : writing or finishing a matrix
//     done_o       : one-cycle completion pulse
//     err_o        : one-cycle pulse when a request names a missing section
// ---------------------------------------------------------------------------
module sp_writeback #(
  parameter int DW           = 8,
  parameter int BW           = 32,
  parameter int MAX_DIM      = BW/DW,
  parameter int SPN          = 1,
  parameter int ADDR_W       = 4,
  parameter int Elements_Num = MAX_DIM*MAX_DIM
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         res_valid_i,
  output logic                         res_ready_o,
  input  logic [BW*Elements_Num-1:0]   res_mat_i,
  input  logic [1:0]                   sp_sel_i,
  input  logic [$clog2(MAX_DIM)-1:0]   rows_m1_i,
  input  logic [$clog2(MAX_DIM)-1:0]   cols_m1_i,
  output logic                         sp_ena_o,
  output logic [ADDR_W-1:0]            sp_addr_o,
  output logic [BW-1:0]                sp_data_o,
  output logic [1:0]                   sp_sel_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int CW = $clog2(MAX_DIM);
  localparam int IW = $clog2(Elements_Num);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   row_q, row_d, col_q, col_d;
  logic [CW-1:0]   rows_q, rows_d, cols_q, cols_d;
  logic [CW-1:0]   last_row, last_col;
  logic [1:0]      sel_q, sel_d;
  logic [BW-1:0]   mat_q [Elements_Num];
  logic [BW-1:0]   mat_d [Elements_Num];
  logic            ena_q, ena_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]   data_q, data_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [IW-1:0]   idx_c;

  // Element outside the latched window reads as zero; in the window-only
  // traversal this never triggers, so one function serves both builds.
  function automatic logic [BW-1:0] wb_data(input logic [CW-1:0] r,
                                            input logic [CW-1:0] c,
                                            input logic [CW-1:0] rm,
                                            input logic [CW-1:0] cm,
                                            input logic [BW-1:0] e);
    return ((r <= rm) && (c <= cm)) ? e : '0;
  endfunction

  function automatic logic [IW-1:0] elem_idx(input logic [CW-1:0] r,
                                             input logic [CW-1:0] c);
    return IW'(int'(r) * MAX_DIM + int'(c));
  endfunction

`ifdef SP_WB_CLEAR_EN
  // Sweep the full matrix regardless of the valid window.
  assign last_row = CW'(MAX_DIM-1);
  assign last_col = CW'(MAX_DIM-1);
`else
  assign last_row = rows_q;
  assign last_col = cols_q;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    sel_d   = sel_q;
    mat_d   = mat_q;
    ena_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    idx_c   = '0;
    unique case (state_q)
      IDLE: begin
        if (res_valid_i) begin
          if (int'(sp_sel_i) >= SPN) begin
            err_d = 1'b1;
          end else begin
            for (int k = 0; k < Elements_Num; k++) begin
              mat_d[k] = res_mat_i[k*BW +: BW];
            end
            rows_d  = rows_m1_i;
            cols_d  = cols_m1_i;
            sel_d   = sp_sel_i;
            row_d   = '0;
            col_d   = '0;
            // Element 0 goes out on the first WRITE cycle.
            ena_d   = 1'b1;
            addr_d  = '0;
            data_d  = res_mat_i[BW-1:0];
            busy_d  = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // row_q/col_q name the element currently on the write port.
        if ((row_q == last_row) && (col_q == last_col)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          if (col_q == last_col) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          idx_c  = elem_idx(row_d, col_d);
          ena_d  = 1'b1;
          addr_d = ADDR_W'(idx_c);
          data_d = wb_data(row_d, col_d, rows_q, cols_q, mat_q[idx_c]);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      sel_q   <= '0;
      for (int k = 0; k < Elements_Num; k++) mat_q[k] <= '0;
      ena_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      sel_q   <= sel_d;
      mat_q   <= mat_d;
      ena_q   <= ena_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign res_ready_o = (state_q == IDLE);
  assign sp_ena_o    = ena_q;
  assign sp_addr_o   = addr_q;
  assign sp_data_o   = data_q;
  assign sp_sel_o    = sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: doc/sp_writeback.md
SP_WRITEBACK -- requirements
Module: sp_writeback

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning matrix element data width.
REQ-002 The block SHALL have parameter BW, default 32, meaning bus and element storage width.
REQ-003 The block SHALL have parameter MAX_DIM, default BW/DW, meaning maximum matrix rows and columns.
REQ-004 The block SHALL have parameter SPN, default 1, meaning number of scratchpad sections (1..4).
REQ-005 The block SHALL have parameter ADDR_W, default 4, meaning scratchpad element address width.
REQ-006 The block SHALL have parameter Elements_Num, default MAX_DIM*MAX_DIM, meaning elements per matrix.
REQ-007 The block SHALL have port clk_i, input, 1 bit: single clock, all state on its rising edge.
REQ-008 The block SHALL have port reset_ni, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port res_valid_i, input, 1 bit: result matrix offered.
REQ-010 The block SHALL have port res_ready_o, output, 1 bit: block can accept a result.
REQ-011 The block SHALL have port res_mat_i, input, BW*Elements_Num bits: flat result matrix, element k at bits [(k+1)*BW-1 -: BW], k = row*MAX_DIM+col.
REQ-012 The block SHALL have port sp_sel_i, input, 2 bits: destination scratchpad section.
REQ-013 The block SHALL have ports rows_m1_i and cols_m1_i, input, $clog2(MAX_DIM) bits each: valid rows-1 and columns-1.
REQ-014 The block SHALL have ports sp_ena_o (1), sp_addr_o (ADDR_W), sp_data_o (BW), sp_sel_o (2), outputs: scratchpad write port.
REQ-015 The block SHALL have ports busy_o, done_o, err_o, outputs, 1 bit each: writing, completion pulse, rejected-request pulse.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, DONE; res_ready_o SHALL be 1 only in IDLE.
REQ-017 In IDLE, res_valid_i&&res_ready_o SHALL latch res_mat_i, sp_sel_i, rows_m1_i, cols_m1_i in the same edge and enter WRITE, row=col=0.
REQ-018 If the accepted sp_sel_i >= SPN, the block SHALL pulse err_o one cycle, perform no writes, and stay in IDLE.
REQ-019 In WRITE, every cycle SHALL drive sp_ena_o=1, sp_addr_o=row*MAX_DIM+col, sp_data_o=latched element at that index, sp_sel_o=latched section, all registered outputs.
REQ-020 Traversal SHALL be row-major: col increments to cols_m1, then wraps to 0 and row increments; after (row,col)=(rows_m1,cols_m1) the FSM SHALL enter DONE.
REQ-021 Latency: first write asserted the cycle after acceptance; exactly (rows_m1+1)*(cols_m1+1) consecutive write cycles with no gaps.
REQ-022 DONE SHALL last one cycle with done_o=1, sp_ena_o=0, then return to IDLE; busy_o SHALL be 1 in WRITE and DONE.
REQ-023 res_valid_i outside IDLE SHALL be ignored; latched data SHALL not change while busy.
REQ-024 When sp_ena_o=0, sp_addr_o, sp_data_o, sp_sel_o SHALL hold their last value.

Reset
REQ-025 reset_ni low SHALL immediately force IDLE and clear sp_ena_o, sp_addr_o, sp_data_o, sp_sel_o, busy_o, done_o, err_o, counters and latched matrix to 0; res_ready_o=1.
REQ-026 Reset asserted mid-WRITE SHALL abort the sequence with no further writes after release until a new acceptance.

Configuration
REQ-027 With macro SP_WB_CLEAR_EN defined, WRITE SHALL sweep all Elements_Num addresses 0..Elements_Num-1, writing the latched element inside the rows/cols window and zero outside it (Elements_Num write cycles).
REQ-028 Without SP_WB_CLEAR_EN, only the in-window elements SHALL be written per REQ-020/021.

Verification
REQ-029 2x2 (rows_m1=cols_m1=1), sel=0, elements k=0..15 = k+1 -> writes (addr,data) (0,1),(1,2),(4,5),(5,6) in 4 consecutive cycles, done_o the 5th cycle.
REQ-030 4x4 full matrix -> 16 writes addr 0..15 in order, then done_o, then res_ready_o=1 next cycle.
REQ-031 SPN=1, sp_sel_i=2 with valid -> err_o one-cycle pulse, sp_ena_o never asserted, stays IDLE.
REQ-032 reset_ni low after 3rd write of a 4x4 -> outputs zero immediately, no writes after release, res_ready_o=1.
REQ-033 res_valid_i toggled with new data during WRITE -> written data unchanged from originally latched matrix.
REQ-034 With SP_WB_CLEAR_EN, 1x1 of value 0xAA -> 16 writes, addr 0 = 0xAA, addr 1..15 = 0.
